// File: rtl/filesystem_router_pkg.sv
// filesystem_router_pkg
// Shared types and constants for the filesystem router:
//   - write / read FSM state encodings
//   - AXI response codes used by the internal DECERR responder
//   - width of the decode-error counter and its saturating increment
package filesystem_router_pkg;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_DATA = 2'd1,
        W_RESP = 2'd2
    } wstate_t;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } rstate_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam int DECERR_CNT_W = 16;

    // Adds 0, 1 or 2 to the counter and clamps at all-ones.
    function automatic logic [DECERR_CNT_W-1:0] decerr_sat_add(
        input logic [DECERR_CNT_W-1:0] i_cnt,
        input logic [1:0]              i_inc
    );
        logic [DECERR_CNT_W:0] w_sum;
        w_sum = {1'b0, i_cnt} + {{(DECERR_CNT_W-1){1'b0}}, i_inc};
        if (w_sum[DECERR_CNT_W]) begin
            return '1;
        end
        return w_sum[DECERR_CNT_W-1:0];
    endfunction

endpackage

// File: rtl/filesystem_addr_decode.sv
// filesystem_addr_decode
// Priority address decoder: the selected file is the lowest index i whose
// exclusive upper limit is above the address. An address at or above the
// last limit matches nothing and raises o_miss.
// Ports:
//   i_addr        address to decode
//   o_sel_onehot  one-hot file select (all zero on a miss)
//   o_miss        no region matched
module filesystem_addr_decode
    import filesystem_router_pkg::*;
#(
    parameter int NUM_FILES         = 8,
    parameter int AXI_ADDR_BITWIDTH = 32,
    parameter logic [NUM_FILES*AXI_ADDR_BITWIDTH-1:0] REGION_LIMITS = '0
) (
    input  logic [AXI_ADDR_BITWIDTH-1:0] i_addr,
    output logic [NUM_FILES-1:0]         o_sel_onehot,
    output logic                         o_miss
);

    logic w_hit;

    always_comb begin
        o_sel_onehot = '0;
        w_hit        = 1'b0;
        for (int i = 0; i < NUM_FILES; i++) begin
            // limits ascend, so the first hit is the owning region
            if (!w_hit && (i_addr < REGION_LIMITS[i*AXI_ADDR_BITWIDTH +: AXI_ADDR_BITWIDTH])) begin
                o_sel_onehot[i] = 1'b1;
                w_hit           = 1'b1;
            end
        end
        o_miss = !w_hit;
    end

endmodule

// File: rtl/filesystem_router.sv
// filesystem_router
// Routes one AXI-subset master port to NUM_FILES file slaves. Each burst is
// decoded at its address handshake; the select is then held until the burst
// (and, for writes, its response) completes. Unmapped bursts are answered by
// an internal DECERR responder and counted in decerr_cnt.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   s_axi_aw*/w*/b*          master write address / data / response
//   s_axi_ar*/r*             master read address / data
//   m_axi_*                  per-file channels, file i in slice i
//   decerr_cnt               saturating count of unmapped bursts
module filesystem_router
    import filesystem_router_pkg::*;
#(
    parameter int NUM_FILES         = 8,
    parameter int AXI_ADDR_BITWIDTH = 32,
    parameter int AXI_DATA_BITWIDTH = 64,
    parameter int AXI_LEN_BITWIDTH  = 4,
    parameter int AXI_STRB_BITWIDTH = 8,
    parameter logic [NUM_FILES*AXI_ADDR_BITWIDTH-1:0] REGION_LIMITS = '0
) (
    input  logic                                    clk,
    input  logic                                    rst,

    input  logic                                    s_axi_awvalid,
    output logic                                    s_axi_awready,
    input  logic [AXI_ADDR_BITWIDTH-1:0]            s_axi_awaddr,
    input  logic [AXI_LEN_BITWIDTH-1:0]             s_axi_awlen,
    input  logic                                    s_axi_wvalid,
    output logic                                    s_axi_wready,
    input  logic [AXI_DATA_BITWIDTH-1:0]            s_axi_wdata,
    input  logic [AXI_STRB_BITWIDTH-1:0]            s_axi_wstrb,
    input  logic                                    s_axi_wlast,
    output logic                                    s_axi_bvalid,
    input  logic                                    s_axi_bready,
    output logic [1:0]                              s_axi_bresp,

    input  logic                                    s_axi_arvalid,
    output logic                                    s_axi_arready,
    input  logic [AXI_ADDR_BITWIDTH-1:0]            s_axi_araddr,
    input  logic [AXI_LEN_BITWIDTH-1:0]             s_axi_arlen,
    output logic                                    s_axi_rvalid,
    input  logic                                    s_axi_rready,
    output logic [AXI_DATA_BITWIDTH-1:0]            s_axi_rdata,
    output logic [1:0]                              s_axi_rresp,
    output logic                                    s_axi_rlast,

    output logic [NUM_FILES-1:0]                    m_axi_awvalid,
    input  logic [NUM_FILES-1:0]                    m_axi_awready,
    output logic [NUM_FILES*AXI_ADDR_BITWIDTH-1:0]  m_axi_awaddr,
    output logic [NUM_FILES*AXI_LEN_BITWIDTH-1:0]   m_axi_awlen,
    output logic [NUM_FILES-1:0]                    m_axi_wvalid,
    input  logic [NUM_FILES-1:0]                    m_axi_wready,
    output logic [NUM_FILES*AXI_DATA_BITWIDTH-1:0]  m_axi_wdata,
    output logic [NUM_FILES*AXI_STRB_BITWIDTH-1:0]  m_axi_wstrb,
    output logic [NUM_FILES-1:0]                    m_axi_wlast,
    input  logic [NUM_FILES-1:0]                    m_axi_bvalid,
    output logic [NUM_FILES-1:0]                    m_axi_bready,
    input  logic [NUM_FILES*2-1:0]                  m_axi_bresp,

    output logic [NUM_FILES-1:0]                    m_axi_arvalid,
    input  logic [NUM_FILES-1:0]                    m_axi_arready,
    output logic [NUM_FILES*AXI_ADDR_BITWIDTH-1:0]  m_axi_araddr,
    output logic [NUM_FILES*AXI_LEN_BITWIDTH-1:0]   m_axi_arlen,
    input  logic [NUM_FILES-1:0]                    m_axi_rvalid,
    output logic [NUM_FILES-1:0]                    m_axi_rready,
    input  logic [NUM_FILES*AXI_DATA_BITWIDTH-1:0]  m_axi_rdata,
    input  logic [NUM_FILES*2-1:0]                  m_axi_rresp,
    input  logic [NUM_FILES-1:0]                    m_axi_rlast,

    output logic [DECERR_CNT_W-1:0]                 decerr_cnt
);

    wstate_t                       r_wstate;
    logic [NUM_FILES-1:0]          r_wsel;
    logic                          r_wmiss;
    rstate_t                       r_rstate;
    logic [NUM_FILES-1:0]          r_rsel;
    logic                          r_rmiss;
    logic [AXI_LEN_BITWIDTH-1:0]   r_rcnt;
    logic [DECERR_CNT_W-1:0]       r_decerr_cnt;

    logic [NUM_FILES-1:0]          w_aw_sel;
    logic                          w_aw_miss;
    logic [NUM_FILES-1:0]          w_ar_sel;
    logic                          w_ar_miss;

    // State qualifiers; gating with rst forces every handshake output low
    // during the reset cycle regardless of the state being left.
    logic                          w_st_widle;
    logic                          w_st_wdata;
    logic                          w_st_wresp;
    logic                          w_st_ridle;
    logic                          w_st_rdata;

    logic                          w_aw_rdy_sel;
    logic                          w_w_rdy_sel;
    logic                          w_b_vld_sel;
    logic [1:0]                    w_b_resp_sel;
    logic                          w_ar_rdy_sel;
    logic                          w_r_vld_sel;
    logic [AXI_DATA_BITWIDTH-1:0]  w_r_data_sel;
    logic [1:0]                    w_r_resp_sel;
    logic                          w_r_last_sel;

    logic                          w_aw_fire;
    logic                          w_w_fire;
    logic                          w_b_fire;
    logic                          w_ar_fire;
    logic                          w_r_fire;
    logic [1:0]                    w_dec_inc;

    filesystem_addr_decode #(
        .NUM_FILES         (NUM_FILES),
        .AXI_ADDR_BITWIDTH (AXI_ADDR_BITWIDTH),
        .REGION_LIMITS     (REGION_LIMITS)
    ) u_aw_decode (
        .i_addr       (s_axi_awaddr),
        .o_sel_onehot (w_aw_sel),
        .o_miss       (w_aw_miss)
    );

    filesystem_addr_decode #(
        .NUM_FILES         (NUM_FILES),
        .AXI_ADDR_BITWIDTH (AXI_ADDR_BITWIDTH),
        .REGION_LIMITS     (REGION_LIMITS)
    ) u_ar_decode (
        .i_addr       (s_axi_araddr),
        .o_sel_onehot (w_ar_sel),
        .o_miss       (w_ar_miss)
    );

    // Write path: AW uses the live decode, W and B use the latched select.
    always_comb begin
        w_st_widle    = (r_wstate == W_IDLE) && !rst;
        w_st_wdata    = (r_wstate == W_DATA) && !rst;
        w_st_wresp    = (r_wstate == W_RESP) && !rst;
        m_axi_awvalid = '0;
        m_axi_awaddr  = '0;
        m_axi_awlen   = '0;
        m_axi_wvalid  = '0;
        m_axi_wdata   = '0;
        m_axi_wstrb   = '0;
        m_axi_wlast   = '0;
        m_axi_bready  = '0;
        w_aw_rdy_sel  = 1'b0;
        w_w_rdy_sel   = 1'b0;
        w_b_vld_sel   = 1'b0;
        w_b_resp_sel  = RESP_OKAY;
        for (int i = 0; i < NUM_FILES; i++) begin
            if (w_st_widle && w_aw_sel[i]) begin
                m_axi_awvalid[i]                                          = s_axi_awvalid;
                m_axi_awaddr[i*AXI_ADDR_BITWIDTH +: AXI_ADDR_BITWIDTH]    = s_axi_awaddr;
                m_axi_awlen[i*AXI_LEN_BITWIDTH +: AXI_LEN_BITWIDTH]       = s_axi_awlen;
                w_aw_rdy_sel                                              = m_axi_awready[i];
            end
            if (w_st_wdata && r_wsel[i]) begin
                m_axi_wvalid[i]                                           = s_axi_wvalid;
                m_axi_wdata[i*AXI_DATA_BITWIDTH +: AXI_DATA_BITWIDTH]     = s_axi_wdata;
                m_axi_wstrb[i*AXI_STRB_BITWIDTH +: AXI_STRB_BITWIDTH]     = s_axi_wstrb;
                m_axi_wlast[i]                                            = s_axi_wlast;
                w_w_rdy_sel                                               = m_axi_wready[i];
            end
            if (w_st_wresp && r_wsel[i]) begin
                m_axi_bready[i] = s_axi_bready;
                w_b_vld_sel     = m_axi_bvalid[i];
                w_b_resp_sel    = m_axi_bresp[i*2 +: 2];
            end
        end
        s_axi_awready = w_st_widle && (w_aw_miss || w_aw_rdy_sel);
        s_axi_wready  = w_st_wdata && (r_wmiss || w_w_rdy_sel);
        s_axi_bvalid  = w_st_wresp && (r_wmiss || w_b_vld_sel);
        if (!w_st_wresp) begin
            s_axi_bresp = RESP_OKAY;
        end else if (r_wmiss) begin
            s_axi_bresp = RESP_DECERR;
        end else begin
            s_axi_bresp = w_b_resp_sel;
        end
    end

    // Read path: AR uses the live decode, R uses the latched select or the
    // internal responder, which counts beats down from arlen to find rlast.
    always_comb begin
        w_st_ridle    = (r_rstate == R_IDLE) && !rst;
        w_st_rdata    = (r_rstate == R_DATA) && !rst;
        m_axi_arvalid = '0;
        m_axi_araddr  = '0;
        m_axi_arlen   = '0;
        m_axi_rready  = '0;
        w_ar_rdy_sel  = 1'b0;
        w_r_vld_sel   = 1'b0;
        w_r_data_sel  = '0;
        w_r_resp_sel  = RESP_OKAY;
        w_r_last_sel  = 1'b0;
        for (int i = 0; i < NUM_FILES; i++) begin
            if (w_st_ridle && w_ar_sel[i]) begin
                m_axi_arvalid[i]                                          = s_axi_arvalid;
                m_axi_araddr[i*AXI_ADDR_BITWIDTH +: AXI_ADDR_BITWIDTH]    = s_axi_araddr;
                m_axi_arlen[i*AXI_LEN_BITWIDTH +: AXI_LEN_BITWIDTH]       = s_axi_arlen;
                w_ar_rdy_sel                                              = m_axi_arready[i];
            end
            if (w_st_rdata && r_rsel[i]) begin
                m_axi_rready[i] = s_axi_rready;
                w_r_vld_sel     = m_axi_rvalid[i];
                w_r_data_sel    = m_axi_rdata[i*AXI_DATA_BITWIDTH +: AXI_DATA_BITWIDTH];
                w_r_resp_sel    = m_axi_rresp[i*2 +: 2];
                w_r_last_sel    = m_axi_rlast[i];
            end
        end
        s_axi_arready = w_st_ridle && (w_ar_miss || w_ar_rdy_sel);
        s_axi_rvalid  = w_st_rdata && (r_rmiss || w_r_vld_sel);
        if (!w_st_rdata) begin
            s_axi_rdata = '0;
            s_axi_rresp = RESP_OKAY;
            s_axi_rlast = 1'b0;
        end else if (r_rmiss) begin
            s_axi_rdata = '0;
            s_axi_rresp = RESP_DECERR;
            s_axi_rlast = (r_rcnt == '0);
        end else begin
            s_axi_rdata = w_r_data_sel;
            s_axi_rresp = w_r_resp_sel;
            s_axi_rlast = w_r_last_sel;
        end
    end

    assign w_aw_fire = s_axi_awvalid && s_axi_awready;
    assign w_w_fire  = s_axi_wvalid  && s_axi_wready;
    assign w_b_fire  = s_axi_bvalid  && s_axi_bready;
    assign w_ar_fire = s_axi_arvalid && s_axi_arready;
    assign w_r_fire  = s_axi_rvalid  && s_axi_rready;
    assign w_dec_inc = {1'b0, w_aw_fire && w_aw_miss} + {1'b0, w_ar_fire && w_ar_miss};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wstate     <= W_IDLE;
            r_wsel       <= '0;
            r_wmiss      <= 1'b0;
            r_rstate     <= R_IDLE;
            r_rsel       <= '0;
            r_rmiss      <= 1'b0;
            r_rcnt       <= '0;
            r_decerr_cnt <= '0;
        end else begin
            case (r_wstate)
                W_IDLE: begin
                    if (w_aw_fire) begin
                        r_wsel   <= w_aw_sel;
                        r_wmiss  <= w_aw_miss;
                        r_wstate <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (w_w_fire && s_axi_wlast) begin
                        r_wstate <= W_RESP;
                    end
                end
                W_RESP: begin
                    if (w_b_fire) begin
                        r_wstate <= W_IDLE;
                    end
                end
                default: r_wstate <= W_IDLE;
            endcase

            case (r_rstate)
                R_IDLE: begin
                    if (w_ar_fire) begin
                        r_rsel   <= w_ar_sel;
                        r_rmiss  <= w_ar_miss;
                        r_rcnt   <= s_axi_arlen;
                        r_rstate <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (w_r_fire) begin
                        if (r_rcnt != '0) begin
                            r_rcnt <= r_rcnt - AXI_LEN_BITWIDTH'(1);
                        end
                        if (s_axi_rlast) begin
                            r_rstate <= R_IDLE;
                        end
                    end
                end
                default: r_rstate <= R_IDLE;
            endcase

            r_decerr_cnt <= decerr_sat_add(r_decerr_cnt, w_dec_inc);
        end
    end

    assign decerr_cnt = r_decerr_cnt;

endmodule

// File: tb/tb_filesystem_router.sv
// tb_filesystem_router
// Directed bench for a two-file router (limits 0x1000, 0x2000). Acts as the
// AXI master and as two simple file slave models that always accept and
// return read data {file_index, address + beat}.
module tb_filesystem_router;
    import filesystem_router_pkg::*;

    localparam int NF = 2;
    localparam int A  = 32;
    localparam int D  = 64;
    localparam int L  = 4;
    localparam int S  = 8;
    localparam logic [NF*A-1:0] LIMITS = {32'h0000_2000, 32'h0000_1000};
    localparam int BUDGET = 40;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic          s_axi_awvalid, s_axi_awready;
    logic [A-1:0]  s_axi_awaddr;
    logic [L-1:0]  s_axi_awlen;
    logic          s_axi_wvalid, s_axi_wready, s_axi_wlast;
    logic [D-1:0]  s_axi_wdata;
    logic [S-1:0]  s_axi_wstrb;
    logic          s_axi_bvalid, s_axi_bready;
    logic [1:0]    s_axi_bresp;
    logic          s_axi_arvalid, s_axi_arready;
    logic [A-1:0]  s_axi_araddr;
    logic [L-1:0]  s_axi_arlen;
    logic          s_axi_rvalid, s_axi_rready, s_axi_rlast;
    logic [D-1:0]  s_axi_rdata;
    logic [1:0]    s_axi_rresp;

    logic [NF-1:0]    m_axi_awvalid, m_axi_awready, m_axi_wvalid, m_axi_wready, m_axi_wlast;
    logic [NF*A-1:0]  m_axi_awaddr, m_axi_araddr;
    logic [NF*L-1:0]  m_axi_awlen, m_axi_arlen;
    logic [NF*D-1:0]  m_axi_wdata, m_axi_rdata;
    logic [NF*S-1:0]  m_axi_wstrb;
    logic [NF-1:0]    m_axi_bvalid, m_axi_bready, m_axi_arvalid, m_axi_arready;
    logic [NF-1:0]    m_axi_rvalid, m_axi_rready, m_axi_rlast;
    logic [NF*2-1:0]  m_axi_bresp, m_axi_rresp;
    logic [15:0]      decerr_cnt;

    filesystem_router #(
        .NUM_FILES(NF), .AXI_ADDR_BITWIDTH(A), .AXI_DATA_BITWIDTH(D),
        .AXI_LEN_BITWIDTH(L), .AXI_STRB_BITWIDTH(S), .REGION_LIMITS(LIMITS)
    ) dut (
        .clk(clk), .rst(rst),
        .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
        .s_axi_awaddr(s_axi_awaddr), .s_axi_awlen(s_axi_awlen),
        .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
        .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wlast(s_axi_wlast),
        .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready), .s_axi_bresp(s_axi_bresp),
        .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
        .s_axi_araddr(s_axi_araddr), .s_axi_arlen(s_axi_arlen),
        .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
        .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp), .s_axi_rlast(s_axi_rlast),
        .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
        .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen),
        .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
        .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
        .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready), .m_axi_bresp(m_axi_bresp),
        .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
        .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
        .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
        .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rlast(m_axi_rlast),
        .decerr_cnt(decerr_cnt)
    );

    // ---------------- file slave models ----------------
    logic [NF-1:0] sl_bvalid, sl_rbusy;
    logic [A-1:0]  sl_raddr [NF];
    logic [L-1:0]  sl_rlen  [NF];
    logic [L-1:0]  sl_rbeat [NF];
    int            w_cnt [NF];
    int            r_cnt [NF];
    int            aw_cnt[NF];
    int            ar_cnt[NF];
    logic [D-1:0]  w_last_data [NF];
    logic [S-1:0]  w_last_strb [NF];

    assign m_axi_awready = '1;
    assign m_axi_wready  = '1;
    assign m_axi_arready = '1;

    always_comb begin
        m_axi_bvalid = sl_bvalid;
        m_axi_bresp  = '0;
        m_axi_rvalid = sl_rbusy;
        m_axi_rresp  = '0;
        m_axi_rdata  = '0;
        m_axi_rlast  = '0;
        for (int f = 0; f < NF; f++) begin
            m_axi_rdata[f*D +: D] = {32'(f), sl_raddr[f] + 32'(sl_rbeat[f])};
            m_axi_rlast[f]        = sl_rbusy[f] && (sl_rbeat[f] == sl_rlen[f]);
        end
    end

    initial begin
        for (int f = 0; f < NF; f++) begin
            w_cnt[f] = 0; r_cnt[f] = 0; aw_cnt[f] = 0; ar_cnt[f] = 0;
            sl_raddr[f] = '0; sl_rlen[f] = '0; sl_rbeat[f] = '0;
            w_last_data[f] = '0; w_last_strb[f] = '0;
        end
    end

    always @(posedge clk) begin
        for (int f = 0; f < NF; f++) begin
            if (m_axi_awvalid[f] && m_axi_awready[f]) aw_cnt[f]++;
            if (m_axi_arvalid[f] && m_axi_arready[f]) ar_cnt[f]++;
            if (m_axi_wvalid[f] && m_axi_wready[f]) begin
                w_cnt[f]++;
                w_last_data[f] <= m_axi_wdata[f*D +: D];
                w_last_strb[f] <= m_axi_wstrb[f*S +: S];
            end
            if (m_axi_rvalid[f] && m_axi_rready[f]) r_cnt[f]++;
            if (rst) begin
                sl_bvalid[f] <= 1'b0;
                sl_rbusy[f]  <= 1'b0;
                sl_rbeat[f]  <= '0;
            end else begin
                if (m_axi_wvalid[f] && m_axi_wready[f] && m_axi_wlast[f]) sl_bvalid[f] <= 1'b1;
                else if (sl_bvalid[f] && m_axi_bready[f])                  sl_bvalid[f] <= 1'b0;
                if (m_axi_arvalid[f] && m_axi_arready[f]) begin
                    sl_rbusy[f] <= 1'b1;
                    sl_raddr[f] <= m_axi_araddr[f*A +: A];
                    sl_rlen[f]  <= m_axi_arlen[f*L +: L];
                    sl_rbeat[f] <= '0;
                end else if (sl_rbusy[f] && m_axi_rready[f]) begin
                    if (sl_rbeat[f] == sl_rlen[f]) sl_rbusy[f] <= 1'b0;
                    else                           sl_rbeat[f] <= sl_rbeat[f] + 4'd1;
                end
            end
        end
    end

    // ---------------- checking helpers ----------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // All phase tasks start and end on a falling clock edge.
    task automatic aw_phase(input logic [A-1:0] addr, input logic [L-1:0] len);
        logic hs; int t;
        s_axi_awvalid = 1'b1; s_axi_awaddr = addr; s_axi_awlen = len;
        hs = 1'b0; t = 0;
        do begin #1 hs = s_axi_awready; @(negedge clk); t++; end while (!hs && t < BUDGET);
        s_axi_awvalid = 1'b0; s_axi_awaddr = '0; s_axi_awlen = '0;
        chk("aw_handshake", 64'(hs), 64'd1);
    endtask

    task automatic w_phase(input logic [L-1:0] len, input logic [D-1:0] base, input logic [S-1:0] strb);
        logic hs; int t;
        for (int b = 0; b <= int'(len); b++) begin
            s_axi_wvalid = 1'b1; s_axi_wdata = base + D'(b); s_axi_wstrb = strb;
            s_axi_wlast = (b == int'(len));
            hs = 1'b0; t = 0;
            do begin #1 hs = s_axi_wready; @(negedge clk); t++; end while (!hs && t < BUDGET);
            if (!hs) begin
                chk("w_handshake", 64'(hs), 64'd1);
                break;
            end
        end
        s_axi_wvalid = 1'b0; s_axi_wlast = 1'b0; s_axi_wdata = '0; s_axi_wstrb = '0;
    endtask

    task automatic b_phase(output logic [1:0] resp);
        logic hs; int t;
        s_axi_bready = 1'b1;
        hs = 1'b0; t = 0; resp = 2'b01;
        do begin #1 hs = s_axi_bvalid; resp = s_axi_bresp; @(negedge clk); t++; end
        while (!hs && t < BUDGET);
        s_axi_bready = 1'b0;
        chk("b_handshake", 64'(hs), 64'd1);
    endtask

    task automatic ar_phase(input logic [A-1:0] addr, input logic [L-1:0] len);
        logic hs; int t;
        s_axi_arvalid = 1'b1; s_axi_araddr = addr; s_axi_arlen = len;
        hs = 1'b0; t = 0;
        do begin #1 hs = s_axi_arready; @(negedge clk); t++; end while (!hs && t < BUDGET);
        s_axi_arvalid = 1'b0; s_axi_araddr = '0; s_axi_arlen = '0;
        chk("ar_handshake", 64'(hs), 64'd1);
    endtask

    // Collects beats until rlast or max_beats; beat n should carry base + n*step.
    task automatic r_phase(input int max_beats, input logic [D-1:0] base, input logic [D-1:0] step,
                           output int nbeats, output int data_errs, output logic [1:0] resp_or,
                           output logic saw_last);
        logic hs, l; logic [D-1:0] d; logic [1:0] r; int t;
        s_axi_rready = 1'b1;
        nbeats = 0; data_errs = 0; resp_or = 2'b00; saw_last = 1'b0;
        while (!saw_last && nbeats < max_beats) begin
            hs = 1'b0; t = 0; d = '0; r = '0; l = 1'b0;
            do begin
                #1 hs = s_axi_rvalid; d = s_axi_rdata; r = s_axi_rresp; l = s_axi_rlast;
                @(negedge clk); t++;
            end while (!hs && t < BUDGET);
            if (!hs) begin
                chk("r_handshake", 64'(hs), 64'd1);
                break;
            end
            if (d !== base + step * D'(nbeats)) data_errs++;
            resp_or  = resp_or | r;
            saw_last = l;
            nbeats++;
        end
        s_axi_rready = 1'b0;
    endtask

    typedef struct {
        logic        is_wr;
        logic [31:0] addr;
        logic [3:0]  len;
        int          exp_file;   // NF means unmapped
        logic [1:0]  exp_resp;
        int          exp_beats;
        logic [15:0] exp_decerr;
    } vec_t;

    localparam int NV = 9;
    vec_t vecs[NV];

    initial begin
        logic [1:0]  resp, ro;
        int          nb, de, unstable;
        logic        sl;
        int          snap_w[NF], snap_r[NF], snap_aw[NF], snap_ar[NF];
        logic [D-1:0] base, d0;
        logic        v0, l0;

        vecs[0] = '{1'b1, 32'h0000_0800, 4'd3,  0,  2'b00, 4,  16'd0};
        vecs[1] = '{1'b0, 32'h0000_1000, 4'd3,  1,  2'b00, 4,  16'd0};
        vecs[2] = '{1'b0, 32'h0000_3000, 4'd2,  NF, 2'b11, 3,  16'd1};
        vecs[3] = '{1'b1, 32'h0000_4000, 4'd0,  NF, 2'b11, 1,  16'd2};
        vecs[4] = '{1'b1, 32'h0000_0FFF, 4'd1,  0,  2'b00, 2,  16'd2};
        vecs[5] = '{1'b0, 32'h0000_0000, 4'd0,  0,  2'b00, 1,  16'd2};
        vecs[6] = '{1'b1, 32'h0000_1FFF, 4'd2,  1,  2'b00, 3,  16'd2};
        vecs[7] = '{1'b0, 32'h0000_2000, 4'd0,  NF, 2'b11, 1,  16'd3};
        vecs[8] = '{1'b1, 32'h0000_1000, 4'd15, 1,  2'b00, 16, 16'd3};

        rst = 1'b1;
        s_axi_awvalid = 0; s_axi_awaddr = '0; s_axi_awlen = '0;
        s_axi_wvalid = 0; s_axi_wdata = '0; s_axi_wstrb = '0; s_axi_wlast = 0;
        s_axi_bready = 0;
        s_axi_arvalid = 0; s_axi_araddr = '0; s_axi_arlen = '0;
        s_axi_rready = 0;

        repeat (3) @(negedge clk);
        #1;
        chk("rst_awready", 64'(s_axi_awready), 64'd0);
        chk("rst_arready", 64'(s_axi_arready), 64'd0);
        chk("rst_wready",  64'(s_axi_wready),  64'd0);
        chk("rst_bvalid",  64'(s_axi_bvalid),  64'd0);
        chk("rst_rvalid",  64'(s_axi_rvalid),  64'd0);
        chk("rst_m_valids", 64'({m_axi_awvalid, m_axi_wvalid, m_axi_arvalid}), 64'd0);
        chk("rst_decerr",  64'(decerr_cnt),    64'd0);
        @(negedge clk);
        rst = 1'b0;

        // ---------------- table-driven bursts ----------------
        for (int k = 0; k < NV; k++) begin
            for (int f = 0; f < NF; f++) begin
                snap_w[f] = w_cnt[f]; snap_r[f] = r_cnt[f];
                snap_aw[f] = aw_cnt[f]; snap_ar[f] = ar_cnt[f];
            end
            if (vecs[k].is_wr) begin
                base = 64'hA500_0000_0000_0000 + 64'(k) * 64'h100;
                aw_phase(vecs[k].addr, vecs[k].len);
                w_phase(vecs[k].len, base, 8'(k + 1));
                b_phase(resp);
                chk($sformatf("v%0d_bresp", k), 64'(resp), 64'(vecs[k].exp_resp));
                for (int f = 0; f < NF; f++) begin
                    chk($sformatf("v%0d_wbeats_f%0d", k, f), 64'(w_cnt[f] - snap_w[f]),
                        (f == vecs[k].exp_file) ? 64'(vecs[k].exp_beats) : 64'd0);
                    chk($sformatf("v%0d_aw_f%0d", k, f), 64'(aw_cnt[f] - snap_aw[f]),
                        (f == vecs[k].exp_file) ? 64'd1 : 64'd0);
                end
                if (vecs[k].exp_file < NF) begin
                    chk($sformatf("v%0d_wdata_last", k), w_last_data[vecs[k].exp_file],
                        base + 64'(vecs[k].len));
                    chk($sformatf("v%0d_wstrb", k), 64'(w_last_strb[vecs[k].exp_file]), 64'(k + 1));
                end
                chk($sformatf("v%0d_wstate_idle", k), 64'(dut.r_wstate), 64'(W_IDLE));
            end else begin
                aw_phase_skip: begin end
                ar_phase(vecs[k].addr, vecs[k].len);
                if (vecs[k].exp_file < NF)
                    r_phase(20, {32'(vecs[k].exp_file), vecs[k].addr}, 64'd1, nb, de, ro, sl);
                else
                    r_phase(20, 64'd0, 64'd0, nb, de, ro, sl);
                chk($sformatf("v%0d_rbeats", k), 64'(nb), 64'(vecs[k].exp_beats));
                chk($sformatf("v%0d_rlast", k), 64'(sl), 64'd1);
                chk($sformatf("v%0d_rdata_errs", k), 64'(de), 64'd0);
                chk($sformatf("v%0d_rresp", k), 64'(ro), 64'(vecs[k].exp_resp));
                for (int f = 0; f < NF; f++) begin
                    chk($sformatf("v%0d_rbeats_f%0d", k, f), 64'(r_cnt[f] - snap_r[f]),
                        (f == vecs[k].exp_file) ? 64'(vecs[k].exp_beats) : 64'd0);
                    chk($sformatf("v%0d_ar_f%0d", k, f), 64'(ar_cnt[f] - snap_ar[f]),
                        (f == vecs[k].exp_file) ? 64'd1 : 64'd0);
                end
                chk($sformatf("v%0d_rstate_idle", k), 64'(dut.r_rstate), 64'(R_IDLE));
            end
            chk($sformatf("v%0d_decerr", k), 64'(decerr_cnt), 64'(vecs[k].exp_decerr));
        end

        // ---------------- simultaneous AW (file0) and AR (file1) ----------------
        s_axi_awvalid = 1'b1; s_axi_awaddr = 32'h0000_0100; s_axi_awlen = 4'd1;
        s_axi_arvalid = 1'b1; s_axi_araddr = 32'h0000_1800; s_axi_arlen = 4'd1;
        #1;
        chk("sim_awready", 64'(s_axi_awready), 64'd1);
        chk("sim_arready", 64'(s_axi_arready), 64'd1);
        chk("sim_m_awvalid", 64'(m_axi_awvalid), 64'b01);
        chk("sim_m_arvalid", 64'(m_axi_arvalid), 64'b10);
        @(negedge clk);
        s_axi_awvalid = 1'b0; s_axi_arvalid = 1'b0;
        chk("sim_wstate", 64'(dut.r_wstate), 64'(W_DATA));
        chk("sim_rstate", 64'(dut.r_rstate), 64'(R_DATA));
        w_phase(4'd1, 64'h1234_0000, 8'hF0);
        b_phase(resp);
        chk("sim_bresp", 64'(resp), 64'd0);
        chk("sim_wdata", w_last_data[0], 64'h1234_0001);
        r_phase(8, {32'd1, 32'h0000_1800}, 64'd1, nb, de, ro, sl);
        chk("sim_rbeats", 64'(nb), 64'd2);
        chk("sim_rdata_errs", 64'(de), 64'd0);

        // ---------------- read backpressure ----------------
        ar_phase(32'h0000_0200, 4'd3);
        r_phase(1, {32'd0, 32'h0000_0200}, 64'd1, nb, de, ro, sl);
        chk("bp_first_beat", 64'(nb), 64'd1);
        #1;
        d0 = s_axi_rdata; v0 = s_axi_rvalid; l0 = s_axi_rlast;
        unstable = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk); #1;
            if (s_axi_rdata !== d0 || s_axi_rvalid !== v0 || s_axi_rlast !== l0) unstable++;
        end
        chk("bp_stable", 64'(unstable), 64'd0);
        chk("bp_held_data", d0, {32'd0, 32'h0000_0201});
        @(negedge clk);
        r_phase(8, {32'd0, 32'h0000_0201}, 64'd1, nb, de, ro, sl);
        chk("bp_rest_beats", 64'(nb), 64'd3);
        chk("bp_rest_data_errs", 64'(de), 64'd0);

        // ---------------- reset during beat 2 of a 4-beat write ----------------
        snap_w[0] = w_cnt[0];
        aw_phase(32'h0000_0400, 4'd3);
        w_phase(4'd0, 64'hBEEF, 8'hFF);
        chk("rstw_beat1_taken", 64'(w_cnt[0] - snap_w[0]), 64'd1);
        s_axi_wvalid = 1'b1; s_axi_wdata = 64'hBEF0; s_axi_wstrb = 8'hFF; s_axi_wlast = 1'b0;
        rst = 1'b1;
        #1;
        chk("rstw_wready_low", 64'(s_axi_wready), 64'd0);
        chk("rstw_m_wvalid_low", 64'(m_axi_wvalid), 64'd0);
        @(negedge clk);
        rst = 1'b0; s_axi_wvalid = 1'b0; s_axi_wdata = '0; s_axi_wstrb = '0;
        chk("rstw_wstate", 64'(dut.r_wstate), 64'(W_IDLE));
        chk("rstw_rstate", 64'(dut.r_rstate), 64'(R_IDLE));
        chk("rstw_bvalid", 64'(s_axi_bvalid), 64'd0);
        chk("rstw_rvalid", 64'(s_axi_rvalid), 64'd0);
        chk("rstw_decerr", 64'(decerr_cnt), 64'd0);
        chk("rstw_beats_dropped", 64'(w_cnt[0] - snap_w[0]), 64'd1);
        snap_w[1] = w_cnt[1];
        aw_phase(32'h0000_1400, 4'd1);
        w_phase(4'd1, 64'h7700, 8'h0F);
        b_phase(resp);
        chk("rstw_fresh_bresp", 64'(resp), 64'd0);
        chk("rstw_fresh_beats", 64'(w_cnt[1] - snap_w[1]), 64'd2);

        // ---------------- decerr saturation ----------------
        force dut.r_decerr_cnt = 16'hFFFE;
        @(negedge clk);
        release dut.r_decerr_cnt;
        chk("sat_preload", 64'(decerr_cnt), 64'hFFFE);
        s_axi_awvalid = 1'b1; s_axi_awaddr = 32'h0000_5000; s_axi_awlen = 4'd0;
        s_axi_arvalid = 1'b1; s_axi_araddr = 32'h0000_6000; s_axi_arlen = 4'd0;
        #1;
        chk("sat_awready", 64'(s_axi_awready), 64'd1);
        chk("sat_arready", 64'(s_axi_arready), 64'd1);
        @(negedge clk);
        s_axi_awvalid = 1'b0; s_axi_arvalid = 1'b0;
        chk("sat_decerr_both", 64'(decerr_cnt), 64'hFFFF);
        w_phase(4'd0, 64'h55, 8'h01);
        b_phase(resp);
        chk("sat_bresp", 64'(resp), 64'(RESP_DECERR));
        r_phase(4, 64'd0, 64'd0, nb, de, ro, sl);
        chk("sat_rbeats", 64'(nb), 64'd1);
        chk("sat_rresp", 64'(ro), 64'(RESP_DECERR));
        aw_phase(32'h0000_7000, 4'd0);
        w_phase(4'd0, 64'h66, 8'h01);
        b_phase(resp);
        chk("sat_decerr_hold", 64'(decerr_cnt), 64'hFFFF);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/filesystem_router.md
Name: filesystem_router

Overview:
Parametrised AXI-subset router between one simulation master port and NUM_FILES file-storage slave models.
- Decodes each burst address against per-file exclusive upper limits.
- Locks routing with explicit write/read state machines until the burst completes; adds a write-response (B) channel.
- Services unmapped addresses with an internal DECERR responder, and counts decode errors.

Parameters:
NUM_FILES, 8, number of downstream file slaves (1..16)
AXI_ADDR_BITWIDTH, 32, address width
AXI_DATA_BITWIDTH, 64, data width
AXI_LEN_BITWIDTH, 4, burst length field width (beats = len+1)
AXI_STRB_BITWIDTH, 8, write strobe width (DATA/8)
REGION_LIMITS, {NUM_FILES{32'h0}}, packed NUM_FILES*ADDR vector; slice i = exclusive upper limit of file i; limits strictly ascending

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
s_axi_aw{valid,ready,addr,len}  in/out/in/in  1/1/ADDR/LEN  master write-address channel
s_axi_w{valid,ready,data,strb,last}  in/out/in/in/in  1/1/DATA/STRB/1  master write-data channel
s_axi_b{valid,ready,resp}  out/in/out  1/1/2  master write-response channel
s_axi_ar{valid,ready,addr,len}  in/out/in/in  1/1/ADDR/LEN  master read-address channel
s_axi_r{valid,ready,data,resp,last}  out/in/out/out/out  1/1/DATA/2/1  master read-data channel
m_axi_*  mirrored  NUM_FILES*width  per-file AW/W/B/AR/R signals packed; file i occupies slice i
decerr_cnt  out  16  saturating count of unmapped bursts (reads + writes)

Behaviour:
- Decode: sel = lowest i with addr < REGION_LIMITS[i]; no match -> unmapped (internal responder).
- Write FSM, W_IDLE -> W_DATA -> W_RESP -> W_IDLE:
  - W_IDLE: decode s_axi_awaddr combinationally; forward awvalid/addr/len only to sel; s_axi_awready = m_awready[sel], or 1 if unmapped.
  - On AW handshake latch sel/unmapped flag and go to W_DATA.
  - W_DATA: W routed only to latched sel; unmapped -> wready=1, beats discarded. On wvalid&wready&wlast go to W_RESP.
  - W_RESP: B routed from sel; unmapped -> bvalid=1, bresp=2'b11. On bvalid&bready go to W_IDLE.
  - awready is 0 outside W_IDLE; wready is 0 outside W_DATA.
- Read FSM, R_IDLE -> R_DATA -> R_IDLE:
  - R_IDLE: same decode and forwarding on AR; on AR handshake latch sel, load beat counter = arlen.
  - R_DATA: R routed from sel. Unmapped -> rvalid=1, rdata=0, rresp=2'b11, rlast when counter==0; counter decrements per rvalid&rready.
  - On rvalid&rready&rlast go to R_IDLE. arready is 0 outside R_IDLE.
- Non-selected slaves: valid/ready inputs driven 0, payloads 0.
- Read and write FSMs are independent; simultaneous AW and AR to the same or different files are both accepted the same cycle.
- Zero-added latency: all forwarding is combinational through the latched select; only FSM state, select, and counter are registered.
- decerr_cnt: +1 per unmapped AW or AR handshake; +2 if both occur the same cycle; saturates at 16'hFFFF.
- Reset:
  - FSMs go to IDLE and counter to 0; decerr_cnt=0.
  - All s_axi ready/valid outputs 0; resp/data/last 0; all m_axi valids 0.
  - Reset mid-burst abandons the burst with no response; the slave model is also reset by the shared rst.
- Boundary cases:
  - addr == REGION_LIMITS[i] belongs to file i+1.
  - addr >= REGION_LIMITS[NUM_FILES-1] is unmapped.
  - len=0 gives a single-beat burst; rlast on the first unmapped beat.
  - Backpressure (rready=0, bready=0) holds all outputs stable.

Decomposition:
- Package filesystem_router_pkg:
  - write-state encoding (W_IDLE=0, W_DATA=1, W_RESP=2)
  - read-state encoding (R_IDLE=0, R_DATA=1)
  - RESP_OKAY=2'b00, RESP_DECERR=2'b11
  - DECERR_CNT_W=16
- Sub-module filesystem_addr_decode: parametrised priority compare of an address against REGION_LIMITS; outputs a one-hot select and a miss flag. Instantiated twice, once for AW and once for AR.

Test Plan:
- NUM_FILES=2, limits {0x2000,0x1000}: write len=3 at 0x0800 -> only m file0 sees 4 W beats; bresp=00 from file0; file1 valids stay 0.
- Read len=3 at 0x1000 (boundary) -> routed to file1; 4 R beats; rlast on beat 4; FSM back to R_IDLE the following cycle.
- Read len=2 at 0x3000 -> 3 beats, rdata=0, rresp=11, rlast on beat 3; decerr_cnt=1. Unmapped write len=0 at 0x4000 -> wready=1, bresp=11; decerr_cnt=2.
- Simultaneous AW to file0 and AR to file1 in the same cycle -> both handshake that cycle and complete independently. Hold rready=0 for 5 cycles mid-burst -> rdata stable.
- Assert rst during beat 2 of a 4-beat write -> next cycle all valids/readies 0, both FSMs IDLE; a fresh write then completes normally.
- Force decerr_cnt to 16'hFFFE, then issue simultaneous unmapped AW and AR -> decerr_cnt=16'hFFFF and holds there.
